// File: rtl/bitwise_logic_unit.sv
// Registered bitwise logic unit: eight per-bit operations on WIDTH-bit
// operands, optional chaining of the previous result into operand A, and a
// 2-entry output FIFO with valid/ready handshakes on both sides.
module bitwise_logic_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             chain,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             out_zero,
    output logic             out_parity
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOT  = 3'b110;

    logic [WIDTH-1:0] chain_reg;
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] result;

    logic [WIDTH-1:0] res_mem    [2];
    logic             zero_mem   [2];
    logic             parity_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;

    logic push;
    logic pop;

    // Status and head entry are taken from registered state only, so there is
    // no combinational path from out_ready to in_ready.
    always_comb begin
        in_ready   = (count != 2'd2);
        out_valid  = (count != 2'd0);
        Out        = res_mem[rd_ptr];
        out_zero   = zero_mem[rd_ptr];
        out_parity = parity_mem[rd_ptr];
        push       = in_valid & in_ready;
        pop        = out_valid & out_ready;
    end

    // Operand select and per-bit operation.
    always_comb begin
        a_eff = chain ? chain_reg : A;
        case (op)
            OP_AND:  result = a_eff & B;
            OP_OR:   result = a_eff | B;
            OP_XOR:  result = a_eff ^ B;
            OP_NAND: result = ~(a_eff & B);
            OP_NOR:  result = ~(a_eff | B);
            OP_XNOR: result = ~(a_eff ^ B);
            OP_NOT:  result = ~a_eff;
            default: result = a_eff;
        endcase
    end

    // FIFO storage, pointers, occupancy and chain register.
    // Reset leaves each slot holding a consistent {0, zero=1, parity=0} entry
    // so the head shows the documented reset flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            chain_reg <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                res_mem[i]    <= '0;
                zero_mem[i]   <= 1'b1;
                parity_mem[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                res_mem[wr_ptr]    <= result;
                zero_mem[wr_ptr]   <= (result == '0);
                parity_mem[wr_ptr] <= ^result;
                wr_ptr             <= ~wr_ptr;
                chain_reg          <= result;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/bitwise_logic_unit.md
Name: bitwise_logic_unit

Overview:
- Parametrised, registered successor to the 8-bit bitwise NAND datapath block of the MiniCPU ALU.
- Computes one of eight bitwise operations on WIDTH-bit operands under an op select.
- Optional chaining: the previous result replaces operand A.
- Results leave through a 2-entry output buffer with valid/ready handshakes on both sides, so the ALU can stall without losing results.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operation request valid
- in_ready  output  1  block can accept a request this cycle
- op  input  3  operation select (encoding below)
- chain  input  1  1: use the chain register as operand A instead of port A
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- out_valid  output  1  buffer head holds a valid result
- out_ready  input  1  consumer takes the head this cycle
- Out  output  WIDTH  result at buffer head
- out_zero  output  1  head result == 0
- out_parity  output  1  XOR-reduction of head result

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high on rst; it is sampled only at the rising edge of clk.
- Op encoding (Aeff = chain ? chain_reg : A):
  - 000 AND, 001 OR, 010 XOR
  - 011 NAND: ~(Aeff & B), bitwise
  - 100 NOR, 101 XNOR
  - 110 NOT: ~Aeff, B ignored
  - 111 PASS: Aeff, B ignored
  - All ops are per-bit; no carries; result width is exactly WIDTH.
- Accept: push = in_valid & in_ready at a rising edge. Operands and op are sampled only on push. When in_valid=1 and in_ready=0, the request is held off and nothing is sampled.
- Pop: pop = out_valid & out_ready at a rising edge.
- Chain register: WIDTH bits, reset 0.
  - On each push, it loads the computed result.
  - With chain=1, the op uses chain_reg as it was before that edge.
  - A pop does not affect it.
- Output buffer: 2-entry FIFO of {result, zero, parity}. Flags are computed at push time and stored with the result. Internal count is 0..2.
  - in_ready = (count != 2), combinational from registered count only. It never depends on out_ready; no combinational in->out path.
  - out_valid = (count != 0). Out, out_zero and out_parity show the head entry.
  - Latency: a request pushed at edge N appears on Out from just after edge N (count 0 case): one cycle, registered.
  - Push and pop at the same edge with count 1: count stays 1, head becomes the new result.
  - Push and pop together with count 2 cannot occur, since in_ready=0.
  - Pop with count 2: the second entry becomes head the next cycle.
  - Ordering is strict FIFO; no result is dropped or duplicated.
  - While out_valid=1 and out_ready=0, Out and flags hold stable.
- Reset (synchronous, rst=1 at edge):
  - count=0, pointers=0, chain_reg=0, stored entries=0.
  - Outputs after reset: out_valid=0, in_ready=1, Out=0, out_zero=1, out_parity=0.
  - Reset wins over a simultaneous push/pop; in-flight results are discarded.
  - While rst is held, no push is accepted regardless of in_valid.
- Out holds the storage content while out_valid=0; that value is don't-care to consumers. The bench checks only the reset value.

Test Plan:
- Basic NAND, WIDTH=8: A=8'hF0, B=8'h3C, op=011, out_ready=1 -> next cycle Out=8'hCF, out_valid=1, out_zero=0, out_parity=0.
- Op sweep: A=8'hA5, B=8'h0F, ops 000..111 back-to-back, out_ready=1 -> Out sequence 05, AF, AA, FA, 50, 55, 5A, A5, one per cycle, in_ready stays 1.
- Chaining:
  - Push 1: op=111, A=8'h81.
  - Push 2: op=010, chain=1, B=8'hFF.
  - Push 3: op=000, chain=1, B=8'h7E.
  - Required: Out 81, 7E, 7E. Zero flag on a 4th push (op=000, chain=1, B=8'h81) -> Out=00, out_zero=1.
- Backpressure: out_ready=0, push 3 requests (results 11, 22, 33) -> in_ready drops after 2 accepts; third held. Raise out_ready -> Out 11, 22, 33 in order, no loss.
- Simultaneous push/pop at count 1 with out_ready=1 continuously -> one result per cycle, in_ready never deasserts, order preserved.
- Reset mid-operation: count=2, chain_reg=8'h5A, assert rst for 1 cycle with in_valid=1 -> out_valid=0, Out=0, in_ready=1. Next chained PASS yields Out=00.
